// File: rtl/redmule_ldst_arbiter.sv
// redmule_ldst_arbiter: arbitrates NB_LD load channels and one store channel onto a single TCDM master port
//   clk_i, rst_i, clear_i, enable_i                   : clock, sync reset, sync soft clear, grant enable
//   ld_req_i/ld_add_i/ld_be_i -> ld_gnt_o             : per-channel load request, payload and grant
//   ld_r_valid_o/ld_r_data_o                          : response routed to the issuing channel, data broadcast
//   st_req_i/st_add_i/st_data_i/st_be_i -> st_gnt_o   : store request, payload and grant
//   tcdm_*                                            : TCDM master port (wen=1 means read)
//   outstanding_o, busy_o, err_o                      : in-flight loads, activity, sticky orphan-response error
module redmule_ldst_arbiter #(
  parameter int NB_LD        = 3,
  parameter int DW           = 288,
  parameter int AW           = 32,
  parameter int MAX_OUTST    = 4,
  parameter int ARB_RR       = 1,
  parameter int MAX_ST_BURST = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic [NB_LD-1:0]           ld_req_i,
  input  logic [NB_LD*AW-1:0]        ld_add_i,
  input  logic [NB_LD*DW/8-1:0]      ld_be_i,
  output logic [NB_LD-1:0]           ld_gnt_o,
  output logic [NB_LD-1:0]           ld_r_valid_o,
  output logic [DW-1:0]              ld_r_data_o,
  input  logic                       st_req_i,
  output logic                       st_gnt_o,
  input  logic [AW-1:0]              st_add_i,
  input  logic [DW-1:0]              st_data_i,
  input  logic [DW/8-1:0]            st_be_i,
  output logic                       tcdm_req_o,
  input  logic                       tcdm_gnt_i,
  output logic                       tcdm_wen_o,
  output logic [AW-1:0]              tcdm_add_o,
  output logic [DW-1:0]              tcdm_data_o,
  output logic [DW/8-1:0]            tcdm_be_o,
  input  logic                       tcdm_r_valid_i,
  input  logic [DW-1:0]              tcdm_r_data_i,
  output logic [$clog2(MAX_OUTST):0] outstanding_o,
  output logic                       busy_o,
  output logic                       err_o
);
  localparam int BW = DW / 8;
  localparam int IW = NB_LD > 1 ? $clog2(NB_LD) : 1;
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_ST_BURST + 1);
  logic [IW-1:0] r_fifo [MAX_OUTST];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_ptr, r_lock_idx, w_rr_idx, w_idx, w_j;
  logic [SW-1:0] r_st_cnt;
  logic          r_lock, r_lock_st, r_err;
  logic          w_clr, w_full, w_any_ld, w_st_ok, w_ld_ok, w_sel_st, w_sel_ok, w_gnt, w_push, w_pop;
  assign w_clr    = rst_i | clear_i;
  assign w_full   = r_cnt == CW'(MAX_OUTST);
  assign w_any_ld = |ld_req_i;
  assign w_st_ok  = st_req_i & (r_st_cnt < SW'(MAX_ST_BURST));
  assign w_ld_ok  = w_any_ld & ~w_full;
  // Scan from the RR pointer (or from 0 for fixed priority); descending loop lets the nearest requester win.
  always_comb begin
    w_rr_idx = '0;
    w_j      = '0;
    for (int k = NB_LD - 1; k >= 0; k--) begin
      w_j = IW'((k + (ARB_RR != 0 ? int'(r_ptr) : 0)) % NB_LD);
      if (ld_req_i[w_j]) w_rr_idx = w_j;
    end
  end
  // A presented-but-ungranted request freezes the selection until it is accepted.
  assign w_sel_st      = r_lock ? r_lock_st : w_st_ok;
  assign w_idx         = r_lock ? r_lock_idx : w_rr_idx;
  assign w_sel_ok      = r_lock | w_st_ok | w_ld_ok;
  assign tcdm_req_o    = ~w_clr & (r_lock | (enable_i & w_sel_ok));
  assign w_gnt         = tcdm_req_o & tcdm_gnt_i;
  assign w_push        = w_gnt & ~w_sel_st;
  assign st_gnt_o      = w_gnt & w_sel_st;
  assign ld_gnt_o      = w_push ? NB_LD'(1) << w_idx : '0;
  assign tcdm_wen_o    = ~w_sel_st;
  assign tcdm_add_o    = w_sel_st ? st_add_i : ld_add_i[w_idx*AW +: AW];
  assign tcdm_be_o     = w_sel_st ? st_be_i : ld_be_i[w_idx*BW +: BW];
  assign tcdm_data_o   = w_sel_st ? st_data_i : '0;
  assign w_pop         = tcdm_r_valid_i & (r_cnt != '0) & ~w_clr;
  assign ld_r_valid_o  = w_pop ? NB_LD'(1) << r_fifo[r_rptr] : '0;
  assign ld_r_data_o   = tcdm_r_data_i;
  assign outstanding_o = r_cnt;
  assign busy_o        = w_any_ld | st_req_i | (r_cnt != '0);
  assign err_o         = r_err;
  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_st  <= 1'b0;
      r_lock_idx <= '0;
      r_st_cnt   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_idx;
        r_wptr         <= r_wptr + 1'b1;
        r_ptr          <= (w_idx == IW'(NB_LD - 1)) ? '0 : w_idx + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (tcdm_req_o & ~tcdm_gnt_i) begin
        r_lock     <= 1'b1;
        r_lock_st  <= w_sel_st;
        r_lock_idx <= w_idx;
      end else if (w_gnt) r_lock <= 1'b0;
      // Store credit only drains while loads wait; any load grant or idle load side refills it.
      r_st_cnt <= (~w_any_ld | w_push) ? '0 : r_st_cnt + SW'(st_gnt_o);
      if (tcdm_r_valid_i & (r_cnt == '0)) r_err <= 1'b1;
    end
  end
endmodule

// File: doc/redmule_ldst_arbiter.md
# redmule_ldst_arbiter

Parametrised load/store arbiter between RedMulE's stream sources/sink and the single TCDM master port of the streamer. It generalises the fixed two-level dynamic mux to NB_LD load channels plus one store channel, with selectable round-robin or fixed-priority load arbitration and store-starvation protection. An in-order ID FIFO routes each read response back to the channel that issued it, removing the need for dummy padding channels.

## Interface
- NB_LD, 3: number of load channels (X, W, Y, ...), 1..8.
- DW, 288: data width in bits; BE width is DW/8.
- AW, 32: address width.
- MAX_OUTST, 4: maximum in-flight loads (ID FIFO depth), power of two, ≥2.
- ARB_RR, 1: 1 = round-robin among loads; 0 = fixed priority, lowest index wins.
- MAX_ST_BURST, 8: consecutive store grants allowed while any load is pending.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- enable_i  in  1  when low, no new grants are issued; responses still route.
- ld_req_i  in  NB_LD  per-channel load request.
- ld_add_i  in  NB_LD*AW  per-channel address.
- ld_be_i  in  NB_LD*DW/8  per-channel byte enables.
- ld_gnt_o  out  NB_LD  per-channel grant.
- ld_r_valid_o  out  NB_LD  per-channel response valid (one-hot or zero).
- ld_r_data_o  out  DW  response data, broadcast to all channels.
- st_req_i / st_gnt_o  in/out  1  store request / grant.
- st_add_i  in  AW; st_data_i  in  DW; st_be_i  in  DW/8  store payload.
- tcdm_req_o  out  1; tcdm_gnt_i  in  1; tcdm_wen_o  out  1 (1 = read).
- tcdm_add_o  out  AW; tcdm_data_o  out  DW; tcdm_be_o  out  DW/8.
- tcdm_r_valid_i  in  1; tcdm_r_data_i  in  DW.
- outstanding_o  out  $clog2(MAX_OUTST)+1  in-flight load count.
- busy_o  out  1  any request pending or outstanding_o ≠ 0.
- err_o  out  1  sticky: response received with empty ID FIFO.

## Operation
- Candidate selection, each cycle with no lock: store if st_req_i and store credit available; else a load by ARB_RR policy among ld_req_i, only if the FIFO is not full; else none.
- Store credit: counter st_cnt increments on each store grant while any ld_req_i is high; when it reaches MAX_ST_BURST the store is not eligible until one load is granted (st_cnt → 0). st_cnt also clears whenever no load is pending.
- Lock: if the selected channel is presented (tcdm_req_o=1) and tcdm_gnt_i=0, its index is registered and held as selection until granted; requesters must keep req/payload stable (HCI rule). The lock persists through enable_i low.
- tcdm_* payload muxed from the selected channel; tcdm_wen_o=0 for store, 1 for load; tcdm_data_o = st_data_i on store, '0 on load.
- Grant: selected channel's gnt = tcdm_gnt_i & tcdm_req_o; others 0.
- RR pointer: after a load grant to channel i, the pointer becomes (i+1) mod NB_LD; the search starts at the pointer.
- Load grant pushes the channel index into the ID FIFO; tcdm_r_valid_i pops the head and asserts ld_r_valid_o[head]. Pop and push in the same cycle are both performed; outstanding_o unchanged.
- FIFO full: no load is eligible even if a pop occurs in the same cycle. Stores are unaffected.
- tcdm_r_valid_i with empty FIFO: response dropped, all ld_r_valid_o = 0, err_o set until rst_i/clear_i.
- Stores produce no response tracking; any r_valid is attributed to loads only.

## Timing
- Request path fully combinational: ld/st req → tcdm_req_o, tcdm_gnt_i → *_gnt_o in the same cycle (0 latency).
- Response path combinational: tcdm_r_valid_i → ld_r_valid_o[head] same cycle; r_data passed through unregistered.
- Registered state: ID FIFO, count, RR pointer, lock valid/index, st_cnt, err_o.
- Reset/clear (synchronous): FIFO empty, outstanding_o=0, pointer=0, lock cleared, st_cnt=0, err_o=0; while rst_i or clear_i is high, tcdm_req_o=0, all gnt=0, all ld_r_valid_o=0. A clear with loads in flight discards their IDs; later responses set err_o.
- enable_i low: tcdm_req_o=0 unless locked; the FIFO still pops.

## Test plan
- RR fairness: NB_LD=3, all ld_req_i held, gnt always 1, no store -> grant order 0,1,2,0,1,2; outstanding_o saturates at 4, then grants stall until responses pop.
- Response routing: grants to 2,0,1, responses 3 and 5 cycles later -> ld_r_valid_o = 3'b100, 3'b001, 3'b010 in order, r_data matches.
- Starvation guard: store and load 1 held continuously, MAX_ST_BURST=8 -> 8 store grants, 1 load grant, repeat.
- Lock: tcdm_gnt_i low 4 cycles while channel 1 is presented and channel 0 raises req -> tcdm_add_o stays channel 1's address until granted.
- Simultaneous push/pop at count 3 -> count stays 3; at count 4 with pop -> no load grant that cycle, count goes to 3.
- Error/clear: r_valid with empty FIFO -> err_o=1, no ld_r_valid_o; clear_i mid-burst -> outstanding_o=0, err_o=0 the next cycle.
